// File: rtl/store_write_buffer.sv
// Posted-write FIFO between core store outputs and the data-memory write port.
// Define STORE_WB_FORWARD_EN to let loads forward from the newest pending store to the same word.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [AW-1:0]              ALUResult,
  input  logic [DW-1:0]              WriteData,
  output logic                       Stall,
  output logic                       Empty,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wd,
  input  logic                       mem_ready,
  output logic                       fwd_hit,
  output logic [DW-1:0]              fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] entry_addr_q [DEPTH];
  logic [AW-1:0] entry_addr_d [DEPTH];
  logic [DW-1:0] entry_data_q [DEPTH];
  logic [DW-1:0] entry_data_d [DEPTH];

  logic full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A full buffer rejects stores even when the head drains this cycle,
  // so Stall never depends on mem_ready.
  assign push  = MemWrite & ~full;
  assign Stall = MemWrite & full;
  assign pop   = mem_we & mem_ready;

  assign mem_we   = ~empty;
  assign mem_addr = entry_addr_q[rd_ptr_q];
  assign mem_wd   = entry_data_q[rd_ptr_q];
  assign Empty    = empty;
  assign Count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    entry_addr_d = entry_addr_q;
    entry_data_d = entry_data_q;
    if (push) begin
      entry_addr_d[wr_ptr_q] = ALUResult;
      entry_data_d[wr_ptr_q] = WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; only entries inside the valid window are ever read.
  always_ff @(posedge clk) begin
    entry_addr_q <= entry_addr_d;
    entry_data_q <= entry_data_d;
  end

`ifdef STORE_WB_FORWARD_EN
  logic [PW-1:0] fwd_idx;

  // Walk oldest to youngest so the youngest word match is the one left standing.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) &&
          (entry_addr_q[fwd_idx][AW-1:2] == ALUResult[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data_q[fwd_idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: directed scenarios plus randomized traffic
// against a queue-based model of the pending stores.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [AW-1:0] ALUResult;
  logic [DW-1:0] WriteData;
  logic          Stall, Empty, mem_we, mem_ready, fwd_hit;
  logic [CW-1:0] Count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, fwd_data;

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .Stall(Stall), .Empty(Empty), .Count(Count),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model: pending stores in program order, {addr, data}; front is what memory must see next.
  logic [AW+DW-1:0] exp_q[$];
  int m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Monitor: every accepted memory write must match the oldest pending store.
  initial begin
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (mem_we === 1'b1 && mem_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_mem_write", {32'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(e[AW+DW-1:DW]));
          chk("mem_wd",   64'(mem_wd),   64'(e[DW-1:0]));
        end
      end
    end
  end

  // One clock cycle: drive at posedge+1, check combinational outputs, then account the edge.
  task automatic cycle(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rdy);
    logic          e_hit;
    logic [DW-1:0] e_data;
    MemWrite  = mw;
    ALUResult = a;
    WriteData = d;
    mem_ready = rdy;
    #1;
    chk("stall",  64'(Stall),  64'(mw && (m_cnt == DEPTH)));
    chk("count",  64'(Count),  64'(m_cnt));
    chk("empty",  64'(Empty),  64'(m_cnt == 0));
    chk("mem_we", 64'(mem_we), 64'(m_cnt != 0));
    e_hit  = 1'b0;
    e_data = '0;
`ifdef STORE_WB_FORWARD_EN
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][AW+DW-1:DW+2] == a[AW-1:2]) begin
        e_hit  = 1'b1;
        e_data = exp_q[i][DW-1:0];
        break;
      end
    end
`endif
    chk("fwd_hit",  64'(fwd_hit),  64'(e_hit));
    chk("fwd_data", 64'(fwd_data), 64'(e_data));
    @(posedge clk);
    begin
      bit do_push, do_pop;
      do_push = mw && (m_cnt < DEPTH);
      do_pop  = rdy && (m_cnt > 0);
      if (do_push) exp_q.push_back({a, d});
      m_cnt = m_cnt + int'(do_push) - int'(do_pop);
    end
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (m_cnt > 0 && n < budget) begin
      cycle(1'b0, '0, '0, 1'b1);
      n++;
    end
    cycle(1'b0, '0, '0, 1'b1);
    chk("drained_all", 64'(exp_q.size()), 64'd0);
  endtask

  // Issue a store, holding it while the model says it stalls.
  task automatic store_hold(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            inout logic rdy, input bit toggle);
    bit st;
    int n = 0;
    do begin
      st = (m_cnt == DEPTH);
      cycle(1'b1, a, d, rdy);
      if (toggle) rdy = ~rdy;
      n++;
    end while (st && n < 20);
    if (st) chk("store_hold_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic rdy;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    bit held;

    reset = 1'b0; MemWrite = 1'b1; ALUResult = '0; WriteData = '0; mem_ready = 1'b1;
    #2;
    chk("rst_stall",  64'(Stall),   64'd0);
    chk("rst_empty",  64'(Empty),   64'd1);
    chk("rst_count",  64'(Count),   64'd0);
    chk("rst_mem_we", 64'(mem_we),  64'd0);
    chk("rst_fwd",    64'(fwd_hit), 64'd0);
    MemWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single store with memory ready.
    cycle(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b1);
    drain(10);

    // Fill to full with memory stalled; fifth store held until a slot frees.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + 32'(4*i), 32'hA0 + 32'(i), 1'b0);
    cycle(1'b1, 32'h210, 32'hA4, 1'b0);
    cycle(1'b1, 32'h210, 32'hA4, 1'b1);
    cycle(1'b1, 32'h210, 32'hA4, 1'b1);
    drain(10);

    // Wrap-around: ten stores with mem_ready toggling.
    rdy = 1'b1;
    for (int i = 0; i < 10; i++) store_hold(32'h300 + 32'(4*i), 32'hB00 + 32'(i), rdy, 1'b1);
    drain(20);

    // Push+pop at Count=2 holds Count; Count=4 with pop and MemWrite stalls and drops to 3.
    cycle(1'b1, 32'h400, 32'h1, 1'b0);
    cycle(1'b1, 32'h404, 32'h2, 1'b0);
    cycle(1'b1, 32'h408, 32'h3, 1'b1);
    cycle(1'b1, 32'h40C, 32'h4, 1'b0);
    cycle(1'b1, 32'h410, 32'h5, 1'b0);
    cycle(1'b1, 32'h414, 32'h6, 1'b1);
    cycle(1'b0, '0, '0, 1'b0);
    drain(10);

`ifdef STORE_WB_FORWARD_EN
    cycle(1'b1, 32'h100, 32'h11, 1'b0);
    cycle(1'b1, 32'h100, 32'h22, 1'b0);
    cycle(1'b0, 32'h102, '0, 1'b0);
    chk("fwd_hit_102",  64'(fwd_hit),  64'd1);
    chk("fwd_data_102", 64'(fwd_data), 64'h22);
    cycle(1'b0, 32'h104, '0, 1'b0);
    chk("fwd_hit_104",  64'(fwd_hit),  64'd0);
    drain(10);
`endif

    // Reset asserted mid-cycle with three pending stores.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h500 + 32'(4*i), 32'hC0 + 32'(i), 1'b0);
    MemWrite = 1'b1; mem_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("midrst_mem_we", 64'(mem_we), 64'd0);
    chk("midrst_count",  64'(Count),  64'd0);
    chk("midrst_empty",  64'(Empty),  64'd1);
    chk("midrst_stall",  64'(Stall),  64'd0);
    exp_q.delete();
    m_cnt = 0;
    MemWrite = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1);

    // Randomized traffic; a stalled store is held unchanged until accepted.
    held = 1'b0;
    ra = '0;
    rd = '0;
    for (int i = 0; i < 400; i++) begin
      bit mw;
      if (held) begin
        mw = 1'b1;
      end else begin
        mw = ($urandom_range(0, 3) != 0);
        ra = 32'h100 + 32'($urandom_range(0, 15));
        rd = $urandom;
      end
      held = mw && (m_cnt == DEPTH);
      cycle(mw, ra, rd, 1'($urandom_range(0, 1)));
    end
    drain(20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
